pool_window_gen: RTL
====================

Name: pool_window_gen

Overview:
- Upstream feeder for the 2x2 max-pooling layer of the BNN accelerator.
- Accepts the conv/activation output as a raster-order pixel stream: one pixel per beat, all CH channels in parallel.
- Buffers one image row and emits each non-overlapping 2x2 window as a packed word with a one-cycle valid pulse.
- Drives the pooling layer's valid, data_in and reset_storage inputs directly.

Parameters:
- CH, 6, number of channels carried in parallel.
- DW, 4, bits per pixel per channel (unsigned).
- W, 8, image width in pixels; even, >=2.
- H, 8, image height in pixels; even, >=2.

Ports:
- clk  in  1  clock, rising edge.
- rst  in  1  asynchronous, active-low reset.
- in_valid  in  1  pixel beat valid; every beat is accepted (no backpressure).
- in_sof  in  1  start-of-frame; qualified by in_valid; marks pixel (0,0).
- in_pix  in  CH*DW  pixel; channel k at bits [k*DW +: DW].
- out_valid  out  1  one-cycle pulse; out_win holds a window.
- out_win  out  CH*4*DW  window word; channel k at [k*4*DW +: 4*DW].
- reset_storage  out  1  one-cycle pulse when an in_sof beat is accepted.
- frame_done  out  1  one-cycle pulse coinciding with the last window of a frame.
- sof_err  out  1  one-cycle pulse when in_sof arrives while the current frame is partially received.

Behaviour:
- Reset (rst=0, async): col=0, row=0, line buffer contents don't-care, prev-pixel register=0.
  - out_valid, reset_storage, frame_done, sof_err = 0; out_win = 0.
  - All outputs are registered.
- Counters: col 0..W-1 and row 0..H-1 advance only on accepted beats (in_valid=1).
  - col wraps W-1 -> 0 and increments row.
  - row wraps H-1 -> 0 after pixel (H-1,W-1); the next beat is (0,0) with or without in_sof.
- in_sof with in_valid: the beat is treated as pixel (0,0).
  - Any partial frame is dropped; no window is emitted for it.
  - reset_storage pulses 1 cycle later.
  - sof_err pulses alongside it if the pre-beat position was not (0,0).
  - in_sof without in_valid is ignored.
- Even rows: each pixel is written to line buffer entry [col]. No output.
- Odd rows, even col: the pixel is stored in the prev-pixel register. No output.
- Odd rows, odd col: the window is formed from:
  - TL = buf[col-1], TR = buf[col], BL = prev, BR = in_pix.
  - Per channel k, the 4*DW field is packed as:
    - [DW-1:0] = TL
    - [2DW-1:DW] = TR
    - [3DW-1:2DW] = BL
    - [4DW-1:3DW] = BR
  - out_win registers the window; out_valid=1 in the next cycle (latency 1 from the BR beat).
- out_win holds its last value when out_valid=0.
- Window rate: (W/2)*(H/2) windows per frame (16 at defaults), in raster order of the pooled grid, matching the downstream 16-entry storage order.
- frame_done=1 in the same cycle as out_valid for the window whose BR is pixel (H-1,W-1).
- Gaps (in_valid=0) may occur anywhere; state is held; there is no timeout.
- Line-buffer write and read of the same entry never collide: reads occur only on odd rows, writes only on even rows.
- Reset asserted mid-frame: all state is cleared immediately and any pending out_valid is cancelled. After release, the next accepted beat is (0,0).

Test Plan:
- Pixel pattern: channel k of pixel (r,c) = (8r+c+k) mod 16. Contiguous 64-beat frame with in_sof on beat 0 gives:
  - reset_storage at cycle 1.
  - First out_valid 1 cycle after beat 9 (pixel (1,1)), out_win[15:0] = 16'h9810 and ch1 field = 16'hA921.
  - 16 pulses total; frame_done only on the 16th, with ch0 field = 16'hFE76.
- Same frame with in_valid randomly low ~50% of cycles -> identical 16 windows and values; out_valid never asserted in two consecutive cycles.
- Two back-to-back frames, second without in_sof -> 32 windows; frame_done pulses twice; reset_storage pulses once.
- in_sof on beat 20 of a frame -> sof_err and reset_storage pulse once.
  - Windows already emitted stay valid.
  - Next window is the (1,1) window of the new frame.
  - Exactly 16 windows follow, ending in frame_done.
- rst pulsed low after beat 30 -> all outputs are 0 during reset. A fresh frame after release yields exactly 16 windows with correct values.
- All-0xF pixels on even rows, 0x0 on odd rows -> every window field = 16'h00FF per channel.

Source files
------------

// File: rtl/pool_window_gen.sv
// Raster pixel stream to non-overlapping 2x2 window generator feeding the max-pooling stage.
// One row is buffered; each window is emitted as a packed word with a single-cycle valid.
`timescale 1ns/1ps
module pool_window_gen #(
  parameter int CH = 6,
  parameter int DW = 4,
  parameter int W  = 8,
  parameter int H  = 8
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 in_valid,
  input  logic                 in_sof,
  input  logic [CH*DW-1:0]     in_pix,
  output logic                 out_valid,
  output logic [CH*4*DW-1:0]   out_win,
  output logic                 reset_storage,
  output logic                 frame_done,
  output logic                 sof_err
);

  localparam int CW = (W > 1) ? $clog2(W) : 1;
  localparam int RW = (H > 1) ? $clog2(H) : 1;
  localparam int PW = CH * DW;
  localparam int OW = CH * 4 * DW;

  logic [CW-1:0] col_reg, col_next, pos_col, tl_idx;
  logic [RW-1:0] row_reg, row_next, pos_row;
  logic [PW-1:0] prev_reg;
  logic [PW-1:0] line_buf [W];
  logic [PW-1:0] rd_tl, rd_tr;
  logic [OW-1:0] win_next;
  logic          at_last_col, at_last_row;
  logic          buf_wr, prev_wr, win_fire, not_origin;

  logic          out_valid_reg, reset_storage_reg, frame_done_reg, sof_err_reg;
  logic [OW-1:0] out_win_reg;

  // An accepted start-of-frame beat is always pixel (0,0), whatever the counters say.
  always_comb begin
    pos_col     = in_sof ? '0 : col_reg;
    pos_row     = in_sof ? '0 : row_reg;
    at_last_col = (pos_col == CW'(W - 1));
    at_last_row = (pos_row == RW'(H - 1));
    buf_wr      = in_valid && !pos_row[0];
    prev_wr     = in_valid &&  pos_row[0] && !pos_col[0];
    win_fire    = in_valid &&  pos_row[0] &&  pos_col[0];
    not_origin  = (col_reg != '0) || (row_reg != '0);
    tl_idx      = pos_col - CW'(1);
    col_next    = at_last_col ? '0 : pos_col + CW'(1);
    row_next    = pos_row;
    if (at_last_col) begin
      row_next = at_last_row ? '0 : pos_row + RW'(1);
    end
  end

  assign rd_tl = line_buf[tl_idx];
  assign rd_tr = line_buf[pos_col];

  generate
    for (genvar gi = 0; gi < CH; gi++) begin : g_pack
      assign win_next[gi*4*DW +: 4*DW] = {in_pix[gi*DW +: DW], prev_reg[gi*DW +: DW],
                                          rd_tr[gi*DW +: DW], rd_tl[gi*DW +: DW]};
    end
  endgenerate

  // Buffer contents need no reset: every entry is rewritten on an even row before it is read.
  always_ff @(posedge clk) begin
    if (buf_wr) begin
      line_buf[pos_col] <= in_pix;
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      col_reg           <= '0;
      row_reg           <= '0;
      prev_reg          <= '0;
      out_valid_reg     <= 1'b0;
      out_win_reg       <= '0;
      reset_storage_reg <= 1'b0;
      frame_done_reg    <= 1'b0;
      sof_err_reg       <= 1'b0;
    end else begin
      out_valid_reg     <= win_fire;
      frame_done_reg    <= win_fire && at_last_col && at_last_row;
      reset_storage_reg <= in_valid && in_sof;
      sof_err_reg       <= in_valid && in_sof && not_origin;
      if (in_valid) begin
        col_reg <= col_next;
        row_reg <= row_next;
      end
      if (prev_wr) begin
        prev_reg <= in_pix;
      end
      if (win_fire) begin
        out_win_reg <= win_next;
      end
    end
  end

  assign out_valid     = out_valid_reg;
  assign out_win       = out_win_reg;
  assign reset_storage = reset_storage_reg;
  assign frame_done    = frame_done_reg;
  assign sof_err       = sof_err_reg;

endmodule
